// File: rtl/fifo_mc_pkg.sv
// Shared types and helpers for the multi-channel FIFO.
// The pointer and channel typedefs are sized from FIFO_MC_N / FIFO_MC_C.
package fifo_mc_pkg;

    localparam int unsigned FIFO_MC_N = 16;
    localparam int unsigned FIFO_MC_C = 4;
    localparam int unsigned PTR_W     = $clog2(FIFO_MC_N);
    localparam int unsigned CH_W      = (FIFO_MC_C > 1) ? $clog2(FIFO_MC_C) : 1;
    localparam int unsigned ADDR_W    = CH_W + PTR_W;

    // The extra x bit tells a full queue from an empty one.
    typedef struct packed {
        logic             x;
        logic [PTR_W-1:0] a;
    } addr_t;

    typedef logic [CH_W-1:0] ch_t;

    function automatic logic [ADDR_W-1:0] mem_addr(input ch_t ch, input logic [PTR_W-1:0] a);
        return {ch, a};
    endfunction

endpackage

// File: rtl/dpsram.sv
// Simple dual-port RAM: one write port and one registered read port on a single clock.
module dpsram #(
    parameter int unsigned W  = 32,
    parameter int unsigned D  = 64,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_mc_ptr.sv
// One channel's write/read pointer pair with registered empty/full flags.
// Flags are derived from next-state pointers so they are exact one cycle after a push/pop.
module fifo_mc_ptr
    import fifo_mc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_en,
    input  logic             pop_en,
    output logic [PTR_W-1:0] wa,
    output logic [PTR_W-1:0] ra,
    output logic             empty_r,
    output logic             full_r
);

    addr_t wptr_q, wptr_d;
    addr_t rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q + {{PTR_W{1'b0}}, push_en};
        rptr_d = rptr_q + {{PTR_W{1'b0}}, pop_en};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            empty_r <= (rptr_d == wptr_d);
            full_r  <= (wptr_d.x != rptr_d.x) && (wptr_d.a == rptr_d.a);
        end
    end

    assign wa = wptr_q.a;
    assign ra = rptr_q.a;

endmodule

// File: rtl/fifo_mc.sv
// Single-clock FIFO with C logical queues of depth N sharing one dpsram of C*N words.
// Define FIFO_MC_ERR_EN to add the sticky err_r port ([0] dropped push, [1] dropped pop).
module fifo_mc
    import fifo_mc_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned N = FIFO_MC_N,
    parameter int unsigned C = FIFO_MC_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [CH_W-1:0] push_ch,
    input  logic [W-1:0]    push_data,
    input  logic            pop,
    input  logic [CH_W-1:0] pop_ch,
    output logic [W-1:0]    pop_data,
    output logic            pop_data_vld_r,
    output logic [C-1:0]    empty_r,
    output logic [C-1:0]    full_r
`ifdef FIFO_MC_ERR_EN
    ,
    output logic [1:0]      err_r
`endif
);

    // The package typedefs are sized from its own constants, so the parameters must agree.
    if (N < 2 || (N & (N - 1)) != 0 || N != FIFO_MC_N) begin : g_bad_n
        $fatal(1, "fifo_mc: N must be a power of 2 >= 2 matching FIFO_MC_N");
    end
    if (C < 1 || C != FIFO_MC_C) begin : g_bad_c
        $fatal(1, "fifo_mc: C must be >= 1 and match FIFO_MC_C");
    end

    logic [PTR_W-1:0]  wa [C];
    logic [PTR_W-1:0]  ra [C];
    logic              push_ok;
    logic              pop_ok;
    logic [C-1:0]      push_en;
    logic [C-1:0]      pop_en;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;

    // Illegal requests are dropped here; the pointers never see them.
    always_comb begin
        push_ok = push && (32'(push_ch) < C) && !full_r[push_ch];
        pop_ok  = pop && (32'(pop_ch) < C) && !empty_r[pop_ch];
        push_en = '0;
        pop_en  = '0;
        for (int unsigned c = 0; c < C; c++) begin
            push_en[c] = push_ok && (32'(push_ch) == c);
            pop_en[c]  = pop_ok && (32'(pop_ch) == c);
        end
        waddr = mem_addr(push_ch, wa[push_ch]);
        raddr = mem_addr(pop_ch, ra[pop_ch]);
    end

    for (genvar c = 0; c < C; c++) begin : g_ch
        fifo_mc_ptr u_ptr (
            .clk     (clk),
            .rst     (rst),
            .push_en (push_en[c]),
            .pop_en  (pop_en[c]),
            .wa      (wa[c]),
            .ra      (ra[c]),
            .empty_r (empty_r[c]),
            .full_r  (full_r[c])
        );
    end

    dpsram #(
        .W  (W),
        .D  (C * N),
        .AW (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (waddr),
        .wdata (push_data),
        .re    (pop_ok),
        .raddr (raddr),
        .rdata (pop_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data_vld_r <= 1'b0;
        end else begin
            pop_data_vld_r <= pop_ok;
        end
    end

`ifdef FIFO_MC_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 2'b00;
        end else begin
            err_r <= err_r | {pop && !pop_ok, push && !push_ok};
        end
    end
`endif

endmodule

// File: tb/tb_fifo_mc.sv
// Directed bench for fifo_mc: vector table for fill/drain and illegal requests,
// plus queue-model sequences for interleaving, steady-state wrap and reset.
module tb_fifo_mc;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic [1:0]  push_ch = 2'd0;
    logic [31:0] push_data = 32'd0;
    logic        pop = 1'b0;
    logic [1:0]  pop_ch = 2'd0;
    logic [31:0] pop_data;
    logic        pop_data_vld_r;
    logic [3:0]  empty_r;
    logic [3:0]  full_r;
`ifdef FIFO_MC_ERR_EN
    logic [1:0]  err_r;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] q [4][$];

    typedef struct {
        logic        push;
        logic [1:0]  pch;
        logic [31:0] pdata;
        logic        pop;
        logic [1:0]  och;
        logic        vld;
        logic [31:0] data;
        logic [3:0]  empty;
        logic [3:0]  full;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    fifo_mc dut (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .push_ch        (push_ch),
        .push_data      (push_data),
        .pop            (pop),
        .pop_ch         (pop_ch),
        .pop_data       (pop_data),
        .pop_data_vld_r (pop_data_vld_r),
        .empty_r        (empty_r),
        .full_r         (full_r)
`ifdef FIFO_MC_ERR_EN
        ,
        .err_r          (err_r)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the queue model, sample #1 after the edge.
    task automatic cyc(input logic r, input logic pu, input logic [1:0] pc, input logic [31:0] pd,
                       input logic po, input logic [1:0] oc, input bit do_chk);
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ee;
        logic [3:0]  ef;
        bit          push_legal;
        bit          pop_legal;
        rst       = r;
        push      = pu;
        push_ch   = pc;
        push_data = pd;
        pop       = po;
        pop_ch    = oc;
        ev = 1'b0;
        ed = '0;
        if (r) begin
            for (int c = 0; c < 4; c++) q[c].delete();
        end else begin
            push_legal = pu && (q[pc].size() < N);
            pop_legal  = po && (q[oc].size() > 0);
            if (pop_legal) begin
                ev = 1'b1;
                ed = q[oc].pop_front();
            end
            if (push_legal) q[pc].push_back(pd);
        end
        for (int c = 0; c < 4; c++) begin
            ee[c] = (q[c].size() == 0);
            ef[c] = (q[c].size() == N);
        end
        @(posedge clk);
        #1;
        if (do_chk) begin
            chk("vld", {31'd0, pop_data_vld_r}, {31'd0, ev});
            if (ev) chk("data", pop_data, ed);
            chk("empty", {28'd0, empty_r}, {28'd0, ee});
            chk("full", {28'd0, full_r}, {28'd0, ef});
        end
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        // Fill and drain ch2, fill ch1, then illegal and same-channel corner cases.
        for (int i = 0; i < 16; i++)
            tbl.push_back('{push: 1'b1, pch: 2'd2, pdata: 32'hA0 + i, pop: 1'b0, och: 2'd0,
                            vld: 1'b0, data: 32'd0, empty: 4'b1011,
                            full: (i == 15) ? 4'b0100 : 4'b0000});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{push: 1'b0, pch: 2'd0, pdata: 32'd0, pop: 1'b1, och: 2'd2,
                            vld: 1'b1, data: 32'hA0 + i,
                            empty: (i == 15) ? 4'b1111 : 4'b1011, full: 4'b0000});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{push: 1'b1, pch: 2'd1, pdata: 32'h10 + i, pop: 1'b0, och: 2'd0,
                            vld: 1'b0, data: 32'd0, empty: 4'b1101,
                            full: (i == 15) ? 4'b0010 : 4'b0000});
        // Push to full ch1 and pop from empty ch0: nothing changes.
        tbl.push_back('{push: 1'b1, pch: 2'd1, pdata: 32'h99, pop: 1'b1, och: 2'd0,
                        vld: 1'b0, data: 32'd0, empty: 4'b1101, full: 4'b0010});
        // Same channel while full: push dropped, pop proceeds.
        tbl.push_back('{push: 1'b1, pch: 2'd1, pdata: 32'h77, pop: 1'b1, och: 2'd1,
                        vld: 1'b1, data: 32'h10, empty: 4'b1101, full: 4'b0000});
        // Same channel while empty: pop dropped, push proceeds.
        tbl.push_back('{push: 1'b1, pch: 2'd0, pdata: 32'h55, pop: 1'b1, och: 2'd0,
                        vld: 1'b0, data: 32'd0, empty: 4'b1100, full: 4'b0000});

        // Reset state with no traffic.
        cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b1);
`ifdef FIFO_MC_ERR_EN
        chk("err_reset", {30'd0, err_r}, 32'd0);
`endif

        foreach (tbl[i]) begin
            cyc(1'b0, tbl[i].push, tbl[i].pch, tbl[i].pdata, tbl[i].pop, tbl[i].och, 1'b0);
            chk($sformatf("tbl%0d_vld", i), {31'd0, pop_data_vld_r}, {31'd0, tbl[i].vld});
            if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), pop_data, tbl[i].data);
            chk($sformatf("tbl%0d_empty", i), {28'd0, empty_r}, {28'd0, tbl[i].empty});
            chk($sformatf("tbl%0d_full", i), {28'd0, full_r}, {28'd0, tbl[i].full});
        end
`ifdef FIFO_MC_ERR_EN
        chk("err_sticky", {30'd0, err_r}, 32'd3);
`endif

        // Interleaved traffic on prefilled ch0 and ch3.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd0, 32'h200 + i, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'd3, 32'h300 + i, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) cyc(1'b0, 1'b1, 2'd0, 32'h1000 + i, 1'b1, 2'd3, 1'b1);
            else            cyc(1'b0, 1'b1, 2'd3, 32'h3000 + i, 1'b1, 2'd0, 1'b1);
        end

        // ch1 down to occupancy 8, then steady push+pop across the pointer wrap.
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 2'd1, 32'h4000 + i, 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 1'b1);
`ifdef FIFO_MC_ERR_EN
        chk("err_held", {30'd0, err_r}, 32'd3);
`endif

        // Pop, then reset on the next cycle with another pop pending.
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 1'b1);
        cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 1'b1);
`ifdef FIFO_MC_ERR_EN
        chk("err_cleared", {30'd0, err_r}, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
